// File: rtl/mem_refill_arbiter_if.sv
// mem_refill_arbiter_if
// Bundle of every handshake and data signal around mem_refill_arbiter. It
// covers the I-cache request side, the D-cache request side and the
// main-memory port.
//   master : arbiter view. It takes the cache requests and memory responses,
//            and drives the acks, read data, word index and memory request.
//   slave  : environment view (cache controllers plus memory model).
// Parameters: ADDR_W (byte address width), DATA_W (word width) and
// LINE_WORDS (words per line, power of two, 2..16).
interface mem_refill_arbiter_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
);
  localparam int unsigned IDX_W = $clog2(LINE_WORDS);

  // I-cache refill engine
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ack;
  logic              ic_done;
  // D-cache refill / writeback engine
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_ack;
  logic              dc_done;
  // shared return path
  logic [DATA_W-1:0] rdata;
  logic [IDX_W-1:0]  word_idx;
  // main-memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
    output ic_ack, ic_done, dc_ack, dc_done, rdata, word_idx,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
    input  ic_ack, ic_done, dc_ack, dc_done, rdata, word_idx,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter
// Shares the single main-memory port between the I-cache refill engine and
// the D-cache refill/writeback engine. A grant covers a whole line of
// LINE_WORDS single-word transfers. Each word is one ISSUE cycle followed by
// WAIT until mem_ack. The winner gets one ack pulse per word in the cycle
// after mem_ack, and one done pulse in the cycle after the last ack.
// Ports:
//   clock : rising-edge clock.
//   reset : asynchronous, active-low.
//   bus   : mem_refill_arbiter_if.master. It carries the cache request/ack
//           pairs, rdata, word_idx and the mem_* request/response handshake.
// Build option:
//   ARB_ROUND_ROBIN_EN defined : round-robin. The last-served requester loses
//                                the next simultaneous contest.
//   undefined (default)        : fixed priority. The data cache wins every
//                                simultaneous contest.
module mem_refill_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_refill_arbiter_if.master bus
);
  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              mem_en_c;

  logic              grant_dc;
  logic              we_q;
  logic [ADDR_W-1:0] line_addr;
  logic [IDX_W-1:0]  word_idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ic_ack_q;
  logic              dc_ack_q;
  logic              ic_done_q;
  logic              dc_done_q;

  logic              any_req;
  logic              prio_dc;
  logic              pick_dc;
  logic              last_word;

  assign any_req   = bus.ic_req | bus.dc_req;
  assign pick_dc   = bus.dc_req & (~bus.ic_req | prio_dc);
  assign last_word = (word_idx_q == LAST_IDX);

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data cache wins the next contest. After each line it points away
  // from the requester just served.
  logic ptr_dc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_dc <= 1'b1;
    end else if (state == DONE) begin
      ptr_dc <= ~grant_dc;
    end
  end

  assign prio_dc = ptr_dc;
`else
  assign prio_dc = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_c  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        mem_en_c = 1'b1;
        if (bus.mem_ack) begin
          state_nxt = last_word ? DONE : ISSUE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latched grant/address, word sequencing and the one-cycle ack/done pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_dc   <= 1'b0;
      we_q       <= 1'b0;
      line_addr  <= '0;
      word_idx_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
      ic_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
    end else begin
      ic_ack_q  <= 1'b0;
      dc_ack_q  <= 1'b0;
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_dc   <= pick_dc;
            we_q       <= pick_dc & bus.dc_we;
            line_addr  <= (pick_dc ? bus.dc_addr : bus.ic_addr) & LINE_MASK;
            word_idx_q <= '0;
          end
        end
        ISSUE: begin
          if (we_q) begin
            wdata_q <= bus.dc_wdata;
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            ic_ack_q <= ~grant_dc;
            dc_ack_q <= grant_dc;
            if (!we_q) begin
              rdata_q <= bus.mem_rdata;
            end
            if (!last_word) begin
              word_idx_q <= word_idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          ic_done_q <= ~grant_dc;
          dc_done_q <= grant_dc;
        end
        default: begin
        end
      endcase
    end
  end

  // During ISSUE the D-cache's current word is passed straight through, so
  // the request is complete in its first cycle. wdata_q holds that word for
  // the rest of WAIT.
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_en_c & we_q;
  assign bus.mem_addr  = line_addr + {{(ADDR_W-OFF_W){1'b0}}, word_idx_q, 2'b00};
  assign bus.mem_wdata = ((state == ISSUE) && we_q) ? bus.dc_wdata : wdata_q;
  assign bus.word_idx  = word_idx_q;
  assign bus.rdata     = rdata_q;
  assign bus.ic_ack    = ic_ack_q;
  assign bus.dc_ack    = dc_ack_q;
  assign bus.ic_done   = ic_done_q;
  assign bus.dc_done   = dc_done_q;
endmodule

// File: tb/tb_mem_refill_arbiter.sv
`timescale 1ns/1ps
module tb_mem_refill_arbiter;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LINE_WORDS = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_refill_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) bus ();

  mem_refill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Memory responder and D-cache write data
  logic        rsp_ack   = 1'b0;
  logic [31:0] rsp_data  = 32'hDEADBEEF;
  logic        force_ack = 1'b0;
  int          rsp_cnt   = 0;
  int          slow_word = -1;
  int          slow_delay = 1;
  assign bus.mem_ack   = rsp_ack | force_ack;
  assign bus.mem_rdata = rsp_data;
  assign bus.dc_wdata  = 32'h11 * (32'(bus.word_idx) + 32'd1);

  // Transaction model state
  bit          m_busy, m_dc, m_we, m_last_dc, win_dc, exp_en;
  int          m_word;
  logic [31:0] m_base, m_rdata;
  bit          p_ic, p_dc, p_dc_we;
  logic [31:0] p_ic_addr, p_dc_addr;
  bit          f_fire, f_dc, f_we, f_last, done_pend, d_dc;
  logic [31:0] f_data;
  int          en_cnt;

  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [31:0] log_rdata[$];
  bit          log_we[$];
  bit          log_done[$];

  // Compare process: checks each cycle against the model, then plays memory.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_ic_ack", bus.ic_ack, 1'b0);
        chk("rst_dc_done", bus.dc_done, 1'b0);
        chk("rst_word_idx", 32'(bus.word_idx), 32'd0);
        m_busy = 0; m_word = 0; m_rdata = '0; m_last_dc = 0;
        p_ic = 0; p_dc = 0; f_fire = 0; f_last = 0; done_pend = 0;
        rsp_ack = 0; rsp_cnt = 0; rsp_data = 32'hDEADBEEF;
      end else begin
        if (!m_busy && (p_ic || p_dc)) begin
`ifdef ARB_ROUND_ROBIN_EN
          win_dc = p_dc && (!p_ic || !m_last_dc);
`else
          win_dc = p_dc;
`endif
          m_busy = 1; m_dc = win_dc; m_we = win_dc & p_dc_we; m_word = 0;
          m_base = (win_dc ? p_dc_addr : p_ic_addr) & ~(32'(LINE_WORDS * 4) - 32'd1);
        end
        exp_en = m_busy && (m_word < LINE_WORDS);
        chk("mem_en", bus.mem_en, exp_en);
        if (exp_en) begin
          chk("mem_addr", bus.mem_addr, m_base + 32'(4 * m_word));
          chk("word_idx", 32'(bus.word_idx), 32'(m_word));
          chk("mem_we", bus.mem_we, m_we);
          if (m_we) chk("mem_wdata", bus.mem_wdata, 32'h11 * 32'(m_word + 1));
        end
        if (f_fire && !f_we) m_rdata = f_data;
        chk("ic_ack", bus.ic_ack, f_fire && !f_dc);
        chk("dc_ack", bus.dc_ack, f_fire && f_dc);
        chk("rdata", bus.rdata, m_rdata);
        if (bus.ic_ack || bus.dc_ack) log_rdata.push_back(bus.rdata);
        chk("ic_done", bus.ic_done, done_pend && !d_dc);
        chk("dc_done", bus.dc_done, done_pend && d_dc);
        if (bus.ic_done || bus.dc_done) log_done.push_back(bus.dc_done);
        if (done_pend) begin
          m_busy = 0;
          m_last_dc = d_dc;
        end
        done_pend = f_fire && f_last;
        d_dc = f_dc;
        if (bus.mem_en) begin
          if (rsp_cnt == ((m_word == slow_word) ? slow_delay : 1)) begin
            rsp_ack = 1; rsp_data = 32'hA0 + {26'b0, bus.mem_addr[7:2]}; rsp_cnt = 0;
          end else begin
            rsp_ack = 0; rsp_data = 32'hDEADBEEF; rsp_cnt++;
          end
          en_cnt++;
        end else begin
          rsp_ack = 0; rsp_data = 32'hDEADBEEF; rsp_cnt = 0;
        end
        f_fire = exp_en && (rsp_ack || force_ack);
        f_dc = m_dc; f_we = m_we; f_data = rsp_data;
        if (f_fire) begin
          log_addr.push_back(bus.mem_addr);
          log_we.push_back(bus.mem_we);
          log_wdata.push_back(bus.mem_wdata);
          m_word++;
        end
        f_last = f_fire && (m_word == LINE_WORDS);
        p_ic = bus.ic_req; p_dc = bus.dc_req; p_dc_we = bus.dc_we;
        p_ic_addr = bus.ic_addr; p_dc_addr = bus.dc_addr;
      end
    end
  end

  task automatic clear_logs();
    log_addr.delete(); log_wdata.delete(); log_rdata.delete();
    log_we.delete(); log_done.delete(); en_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.ic_req = 0; bus.dc_req = 0; bus.dc_we = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic wait_done(input bit dc, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clock); #1; n++;
      if (dc ? bus.dc_done : bus.ic_done) return;
    end
    chk(dc ? "dc_done_timeout" : "ic_done_timeout", 32'(n), 32'd0);
  endtask

  task automatic requester(input bit dc, input logic [31:0] base, input int lines);
    int n;
    for (int l = 0; l < lines; l++) begin
      wait_done(dc, 80, n);
      if (l == lines - 1) begin
        if (dc) bus.dc_req = 0; else bus.ic_req = 0;
      end else begin
        if (dc) bus.dc_addr = base + 32'(16 * (l + 1));
        else    bus.ic_addr = base + 32'(16 * (l + 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int lat;
    bit exp_order[4];
    logic [31:0] exp_w[4];
    bus.ic_req = 0; bus.ic_addr = '0; bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = '0;

    #2 reset = 1'b0;
    #1;
    chk("t0_mem_en", bus.mem_en, 1'b0);
    chk("t0_mem_addr", bus.mem_addr, 32'h0);
    chk("t0_mem_wdata", bus.mem_wdata, 32'h0);
    chk("t0_rdata", bus.rdata, 32'h0);
    chk("t0_acks_dones", {28'b0, bus.ic_ack, bus.dc_ack, bus.ic_done, bus.dc_done}, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // 1: single I-cache refill from an unaligned address
    clear_logs();
    @(posedge clock); #1;
    bus.ic_addr = 32'h104; bus.ic_req = 1;
    wait_done(0, 40, lat);
    bus.ic_req = 0;
    chk("t1_latency", 32'(lat), 32'd10);
    repeat (3) @(posedge clock);
    chk("t1_words", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", log_addr[i], 32'h100 + 32'(4 * i));
      chk("t1_rdata", log_rdata[i], 32'hA0 + 32'(i));
    end
    chk("t1_done_count", 32'(log_done.size()), 32'd1);

    // 2: D-cache writeback
    do_reset(); clear_logs();
    exp_w = '{32'h11, 32'h22, 32'h33, 32'h44};
    bus.dc_addr = 32'h200; bus.dc_we = 1; bus.dc_req = 1;
    wait_done(1, 40, lat);
    bus.dc_req = 0; bus.dc_we = 0;
    repeat (3) @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", log_addr[i], 32'h200 + 32'(4 * i));
      chk("t2_we", 32'(log_we[i]), 32'd1);
      chk("t2_wdata", log_wdata[i], exp_w[i]);
    end
    chk("t2_done_count", 32'(log_done.size()), 32'd1);
    chk("t2_done_is_dc", 32'(log_done[0]), 32'd1);

    // 3: both caches request two lines each at the same time
    do_reset(); clear_logs();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
    bus.ic_addr = 32'h1000; bus.dc_addr = 32'h2000; bus.dc_we = 0;
    bus.ic_req = 1; bus.dc_req = 1;
    fork
      requester(0, 32'h1000, 2);
      requester(1, 32'h2000, 2);
    join
    repeat (3) @(posedge clock);
    chk("t3_done_count", 32'(log_done.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_order", 32'(log_done[i]), 32'(exp_order[i]));

    // 4: memory answers word 2 after 5 cycles
    do_reset(); clear_logs();
    slow_word = 2; slow_delay = 5;
    bus.ic_addr = 32'h300; bus.ic_req = 1;
    wait_done(0, 40, lat);
    bus.ic_req = 0;
    repeat (3) @(posedge clock);
    slow_word = -1; slow_delay = 1;
    chk("t4_latency", 32'(lat), 32'd14);
    chk("t4_en_cycles", 32'(en_cnt), 32'd12);
    chk("t4_ack_count", 32'(log_rdata.size()), 32'd4);
    chk("t4_rdata2", log_rdata[2], 32'hA2);

    // 5: reset in the WAIT cycle of word 1
    do_reset(); clear_logs();
    bus.ic_addr = 32'h400; bus.ic_req = 1;
    lat = 0;
    do begin
      @(posedge clock); #1; lat++;
    end while (!(bus.mem_en && bus.word_idx == 2'd1) && lat < 40);
    @(posedge clock); #1;
    chk("t5_in_wait_w1", {30'b0, bus.mem_en, bus.word_idx[0]}, 32'd3);
    reset = 1'b0;
    #1;
    chk("t5_async_mem_en", bus.mem_en, 1'b0);
    chk("t5_async_mem_addr", bus.mem_addr, 32'h0);
    chk("t5_async_word_idx", 32'(bus.word_idx), 32'd0);
    chk("t5_async_rdata", bus.rdata, 32'h0);
    bus.ic_req = 0;
    @(posedge clock); #1;
    reset = 1'b1;
    clear_logs();
    bus.ic_addr = 32'h500; bus.ic_req = 1;
    wait_done(0, 40, lat);
    bus.ic_req = 0;
    chk("t5_latency", 32'(lat), 32'd10);
    chk("t5_first_addr", log_addr[0], 32'h500);

    // 6: dc_req dropped mid-burst, then a spurious mem_ack while idle
    do_reset(); clear_logs();
    bus.dc_addr = 32'h600; bus.dc_we = 0; bus.dc_req = 1;
    repeat (3) @(posedge clock); #1;
    bus.dc_req = 0;
    wait_done(1, 40, lat);
    @(posedge clock); #1 force_ack = 1;
    @(posedge clock); #1 force_ack = 0;
    repeat (4) @(posedge clock);
    chk("t6_ack_count", 32'(log_rdata.size()), 32'd4);
    chk("t6_rdata0", log_rdata[0], 32'hA0);
    chk("t6_done_count", 32'(log_done.size()), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Sequential arbiter that shares the single main-memory port between the instruction-cache refill engine and the data-cache refill/writeback engine of the cached RV32I core. It grants the port to one requester at a time for a whole cache-line burst of `LINE_WORDS` single-word transfers, sequences the burst word by word over a request/acknowledge memory handshake, and returns per-word acknowledges plus an end-of-line pulse. It sits between the two cache controllers and the main-memory model inside `cpu`.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width.
- `LINE_WORDS`, 4: words per line; power of two, 2..16.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 = reset.
- `ic_req` in 1: I-cache line request (read only); held high until `ic_done`.
- `ic_addr` in ADDR_W: line-aligned address; stable while `ic_req`.
- `ic_ack` out 1: one-cycle pulse per word returned to I-cache.
- `ic_done` out 1: one-cycle pulse after the last word.
- `dc_req` in 1: D-cache line request; held until `dc_done`.
- `dc_we` in 1: 1 = writeback, 0 = refill; stable while `dc_req`.
- `dc_addr` in ADDR_W: line-aligned address.
- `dc_wdata` in DATA_W: write word selected by `word_idx`.
- `dc_ack`, `dc_done` out 1: as for I-cache.
- `rdata` out DATA_W: read word, valid when `ic_ack` or `dc_ack`.
- `word_idx` out log2(LINE_WORDS): index of the word in flight.
- `mem_en` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: write strobe.
- `mem_addr` out ADDR_W: `line_addr + 4*word_idx`.
- `mem_wdata` out DATA_W: registered copy of `dc_wdata`.
- `mem_ack` in 1: memory completion, one cycle, ≥1 cycle after `mem_en` rises.
- `mem_rdata` in DATA_W: valid with `mem_ack`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: no request → stay. Any request → latch winner, `we`, and address; `word_idx`=0 → ISSUE.
- ISSUE: assert `mem_en` with address, `we`, and wdata (sampled from `dc_wdata` this cycle) → WAIT.
- WAIT: `mem_en` stays high and outputs stay stable. On `mem_ack`: register `mem_rdata` into `rdata` and pulse the winner's ack next cycle. If `word_idx`==LINE_WORDS-1 → DONE, else increment `word_idx` → ISSUE.
- DONE: pulse winner's done for one cycle, drop the grant, update priority → IDLE.
- Acks also pulse for writes; `rdata` is then don't-care and holds its previous value.
- Address arithmetic is modulo 2^ADDR_W; low log2(LINE_WORDS)+2 bits of the latched address are forced to 0.
- A requester deasserting `req` mid-burst is ignored; the burst completes.
- `mem_ack` outside WAIT is ignored.
- Both requests in the same IDLE cycle: resolved per Configuration.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; `word_idx`=0; priority pointer = data cache.
- Per word: ISSUE 1 cycle + WAIT ≥1 cycle. Ack pulses the cycle after `mem_ack`.
- Line latency with `mem_ack` returned one cycle after `mem_en`: 1 (IDLE) + 2·LINE_WORDS + 1 (DONE) cycles from `req` to the `done` pulse.
- Last ack and done are in consecutive cycles; done never coincides with an ack.
- Back-to-back requests: a new grant is possible the cycle after DONE.
- Reset mid-burst aborts immediately; `mem_en` drops asynchronously.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. The last-served requester loses the next simultaneous contest; the pointer updates in DONE.
- Not defined: fixed priority; the data cache always wins a simultaneous contest. The pointer is absent.

## Test plan
- Single I-cache refill, `ic_addr`=0x104, `mem_ack` one cycle after `mem_en`, memory returns 0xA0..0xA3 → `mem_addr` 0x100,0x104,0x108,0x10C; four `ic_ack` with `rdata` 0xA0..0xA3; `ic_done` at cycle 10 after `req`.
- D-cache writeback, `dc_addr`=0x200, `dc_wdata`=0x11·(idx+1) → four writes with `mem_we`=1, data 0x11,0x22,0x33,0x44; `dc_done` pulses once.
- Simultaneous `ic_req`/`dc_req`, two lines each: without the macro the D-cache is served first; with the macro the order is D, I, D, I.
- `mem_ack` delayed 5 cycles on word 2 → `mem_en`/`mem_addr` held stable for 5 cycles; no extra ack; total latency +4.
- Reset low in WAIT of word 1 → all outputs 0 immediately; after release a new `ic_req` starts at word 0.
- `dc_req` dropped mid-burst, then a spurious `mem_ack` in IDLE → burst completes; the spurious ack produces no output pulse.
